// File: rtl/array_pkg.sv
// rtl/array_pkg.sv - shared defaults and FSM encoding for the lane-wise array accumulator
package array_pkg;

  localparam int DEF_LANES  = 9;
  localparam int DEF_LANE_W = 3;
  localparam int DEF_CNT_W  = 4;

  // HOLD is the only state that presents a result to the consumer
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } accState_t;

  function automatic logic stateBusy(input accState_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/array_lane_add.sv
// rtl/array_lane_add.sv - combinational lane-wise adder, each lane wraps and reports its own carry
module array_lane_add
  import array_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] b,
  output logic [LANES*LANE_W-1:0] sum,
  output logic [LANES-1:0]        carry
);

  // One extra bit per lane catches the carry-out; nothing ripples into the next lane
  for (genvar i = 0; i < LANES; i++) begin : gLane
    logic [LANE_W:0] laneTot;
    assign laneTot = {1'b0, a[i*LANE_W +: LANE_W]} + {1'b0, b[i*LANE_W +: LANE_W]};
    assign sum[i*LANE_W +: LANE_W] = laneTot[LANE_W-1:0];
    assign carry[i] = laneTot[LANE_W];
  end

endmodule

// File: rtl/array_accum_ctrl.sv
// rtl/array_accum_ctrl.sv - job controller that sums a counted stream of flat lane arrays
module array_accum_ctrl
  import array_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        count,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [LANES-1:0]        ovf,
  output logic                    busy
);

  localparam int W = LANES * LANE_W;

  accState_t        state;
  accState_t        nextState;
  logic [CNT_W-1:0] remaining;
  logic [W-1:0]     acc;
  logic [W-1:0]     laneSum;
  logic [LANES-1:0] laneCarry;
  logic             beatTaken;

  assign beatTaken = in_valid && in_ready;

  array_lane_add #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) uLaneAdd (
    .a     (acc),
    .b     (in_data),
    .sum   (laneSum),
    .carry (laneCarry)
  );

  // State register; reset aborts any job without presenting a result
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs, all derived from the current state
  always_comb begin
    nextState = state;
    busy      = stateBusy(state);
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = (count == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && remaining == CNT_W'(1)) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Job datapath: latch count, accumulate beats, publish the sum when passing through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      acc       <= '0;
      out_data  <= '0;
      ovf       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= count;
            acc       <= '0;
            ovf       <= '0;
          end
        end
        ACCUM: begin
          if (beatTaken) begin
            acc       <= laneSum;
            ovf       <= ovf | laneCarry;
            remaining <= remaining - CNT_W'(1);
          end
        end
        DONE: begin
          out_data <= acc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_accum_ctrl.sv
// tb/tb_array_accum_ctrl.sv - directed bench with a job-level reference model for array_accum_ctrl
module tb_array_accum_ctrl;

  localparam int LANES  = 9;
  localparam int LANE_W = 3;
  localparam int CNT_W  = 4;
  localparam int W      = LANES * LANE_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [LANES-1:0] ovf;
  logic             busy;

  array_accum_ctrl #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Hand-computed expectations for the current cycle, set by the stimulus
  logic             pinCtlEn  = 1'b0;
  logic             pinBusy   = 1'b0;
  logic             pinRdy    = 1'b0;
  logic             pinVal    = 1'b0;
  logic             pinDataEn = 1'b0;
  logic [W-1:0]     pinData   = '0;
  logic             pinOvfEn  = 1'b0;
  logic [LANES-1:0] pinOvf    = '0;
  string            pinTag    = "";

  // Job-level reference model
  int               cyc         = 0;
  bit               jobOpen     = 1'b0;
  int               jobCount    = 0;
  int               beatsGot    = 0;
  int               finishCycle = 0;
  int               laneAcc[LANES];
  logic [LANES-1:0] runOvf      = '0;
  logic [W-1:0]     lastOut     = '0;

  function automatic logic [W-1:0] packAcc();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = LANE_W'(laneAcc[i]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Compare every cycle against the model and any pinned literals, then advance the model
  always @(negedge clk) begin
    logic         mValid;
    logic         mReady;
    logic [W-1:0] mData;
    mValid = jobOpen && (cyc >= finishCycle);
    mReady = jobOpen && (beatsGot < jobCount);
    mData  = mValid ? packAcc() : lastOut;

    chk("busy", W'(busy), W'(jobOpen));
    chk("in_ready", W'(in_ready), W'(mReady));
    chk("out_valid", W'(out_valid), W'(mValid));
    chk("out_data", out_data, mData);
    chk("ovf", W'(ovf), W'(runOvf));

    if (pinCtlEn) begin
      chk({pinTag, ":busy"}, W'(busy), W'(pinBusy));
      chk({pinTag, ":in_ready"}, W'(in_ready), W'(pinRdy));
      chk({pinTag, ":out_valid"}, W'(out_valid), W'(pinVal));
    end
    if (pinDataEn) chk({pinTag, ":out_data"}, out_data, pinData);
    if (pinOvfEn) chk({pinTag, ":ovf"}, W'(ovf), W'(pinOvf));

    if (rst) begin
      jobOpen = 1'b0;
      runOvf  = '0;
      lastOut = '0;
      for (int i = 0; i < LANES; i++) laneAcc[i] = 0;
    end else if (!jobOpen) begin
      if (start) begin
        jobOpen  = 1'b1;
        jobCount = int'(count);
        beatsGot = 0;
        runOvf   = '0;
        for (int i = 0; i < LANES; i++) laneAcc[i] = 0;
        finishCycle = (count == '0) ? cyc + 2 : 32'h7fffffff;
      end
    end else if (mReady && in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        int s;
        s = laneAcc[i] + int'(in_data[i*LANE_W +: LANE_W]);
        if (s >= (1 << LANE_W)) runOvf[i] = 1'b1;
        laneAcc[i] = s % (1 << LANE_W);
      end
      beatsGot++;
      if (beatsGot == jobCount) finishCycle = cyc + 2;
    end else if (mValid && out_ready) begin
      jobOpen = 1'b0;
      lastOut = mData;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    pinCtlEn  = 1'b0;
    pinDataEn = 1'b0;
    pinOvfEn  = 1'b0;
  endtask

  task automatic pinCtl(input string tag, input logic b, input logic r, input logic v);
    pinTag   = tag;
    pinCtlEn = 1'b1;
    pinBusy  = b;
    pinRdy   = r;
    pinVal   = v;
  endtask

  task automatic pinRes(input logic [W-1:0] d, input logic [LANES-1:0] o);
    pinDataEn = 1'b1;
    pinData   = d;
    pinOvfEn  = 1'b1;
    pinOvf    = o;
  endtask

  task automatic startJob(input string tag, input logic [CNT_W-1:0] cnt);
    pinCtl(tag, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    count = cnt;
    step();
    start = 1'b0;
    count = ~cnt;
  endtask

  task automatic beat(input string tag, input int gap, input logic [W-1:0] d);
    for (int g = 0; g < gap; g++) begin
      pinCtl(tag, 1'b1, 1'b1, 1'b0);
      in_valid = 1'b0;
      step();
    end
    pinCtl(tag, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  // Present in HOLD, consume, and confirm the return to IDLE with the result retained
  task automatic finishJob(input string tag, input logic [W-1:0] d, input logic [LANES-1:0] o);
    pinCtl({tag, "_done"}, 1'b1, 1'b0, 1'b0);
    step();
    pinCtl({tag, "_hold"}, 1'b1, 1'b0, 1'b1);
    pinRes(d, o);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    pinCtl({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
    pinRes(d, o);
    step();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    count     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    pinCtl("reset", 1'b0, 1'b0, 1'b0);
    pinRes('0, '0);
    rst = 1'b0;
    step();

    // Two identical beats back-to-back, mixed carries
    startJob("t1", 4'd2);
    beat("t1", 0, 27'o123456701);
    beat("t1", 0, 27'o123456701);
    finishJob("t1", 27'o246024602, 9'b000111100);

    // Three beats with input gaps 0, 3, 1
    startJob("t2", 4'd3);
    beat("t2", 0, 27'o111111111);
    beat("t2", 3, 27'o111111111);
    beat("t2", 1, 27'o111111111);
    finishJob("t2", 27'o333333333, 9'b0);

    // Empty job goes straight through DONE
    startJob("t3", 4'd0);
    finishJob("t3", 27'o0, 9'b0);

    // Result held under back-pressure while start is pulsed
    startJob("t4", 4'd2);
    beat("t4", 0, 27'o000000456);
    beat("t4", 0, 27'o000000333);
    pinCtl("t4_done", 1'b1, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      pinCtl("t4_stall", 1'b1, 1'b0, 1'b1);
      pinRes(27'o000000701, 9'b000000011);
      start = (k == 2);
      count = 4'd5;
      step();
      start = 1'b0;
    end
    pinCtl("t4_take", 1'b1, 1'b0, 1'b1);
    pinRes(27'o000000701, 9'b000000011);
    out_ready = 1'b1;
    start     = 1'b1;
    count     = 4'd1;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    pinCtl("t4_idle", 1'b0, 1'b0, 1'b0);
    pinRes(27'o000000701, 9'b000000011);
    step();
    pinCtl("t4_idle2", 1'b0, 1'b0, 1'b0);
    step();

    // Reset in the middle of a job, then a fresh single-beat job
    startJob("t5", 4'd4);
    beat("t5", 0, 27'o777777777);
    beat("t5", 0, 27'o777777777);
    pinCtl("t5_mid", 1'b1, 1'b1, 1'b0);
    pinOvfEn = 1'b1;
    pinOvf   = 9'h1FF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    pinCtl("t5_rst", 1'b0, 1'b0, 1'b0);
    pinRes('0, '0);
    step();
    startJob("t5b", 4'd1);
    beat("t5b", 0, 27'o000000007);
    finishJob("t5b", 27'o000000007, 9'b0);

    // Eight all-ones operands wrap every lane to zero
    startJob("t6", 4'd8);
    for (int b = 0; b < 8; b++) beat("t6", 0, 27'o777777777);
    finishJob("t6", 27'o000000000, 9'h1FF);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/array_accum_ctrl.md
ARRAY_ACCUM_CTRL -- requirements
Module: array_accum_ctrl

Interface
REQ-001 Parameter LANES, default 9, number of lanes in a flat array.
REQ-002 Parameter LANE_W, default 3, bits per lane; flat width W = LANES*LANE_W (27 by default).
REQ-003 Parameter CNT_W, default 4, width of the operand count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a new accumulation job; sampled only in IDLE.
REQ-007 count  input  CNT_W  number of operand arrays in the job; latched when start is accepted.
REQ-008 in_valid  input  1  in_data holds an operand.
REQ-009 in_ready  output  1  block accepts an operand this cycle.
REQ-010 in_data  input  W  flat operand; lane i = bits [i*LANE_W +: LANE_W].
REQ-011 out_valid  output  1  result held on out_data and ovf.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  W  lane-wise accumulated sum.
REQ-014 ovf  output  LANES  sticky per-lane overflow flags for the current job.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ACCUM, DONE, and HOLD, where HOLD is the output-presenting state.
REQ-017 IDLE: busy=0, in_ready=0, out_valid=0; start=1 SHALL latch count into remaining, clear the accumulator and ovf, and go to ACCUM, or to DONE when count==0.
REQ-018 ACCUM: in_ready=1; each cycle with in_valid&&in_ready SHALL set acc <= acc (+) in_data lane-wise, OR each lane's carry-out into ovf, and decrement remaining.
REQ-019 The beat that makes remaining reach 0 SHALL be the last accepted beat; the next state is DONE, and in_ready is 0 from the following cycle onward.
REQ-020 Cycles in ACCUM with in_valid=0 SHALL leave all state unchanged; there is no timeout.
REQ-021 Lane arithmetic SHALL wrap modulo 2^LANE_W per lane, with no carry between lanes; overflow is reported only through ovf.
REQ-022 DONE SHALL last one cycle and transfer acc to out_data; state then goes to HOLD.
REQ-023 HOLD: out_valid=1, and out_data and ovf are stable until out_ready=1; on out_valid&&out_ready the next state is IDLE.
REQ-024 Latency: out_valid SHALL rise exactly 2 cycles after the final accepted beat (1 cycle through DONE, then HOLD), or 2 cycles after start when count==0.
REQ-025 start SHALL be ignored while busy=1; count changes outside an accepted start SHALL have no effect.
REQ-026 If start and out_ready are high in the same cycle in HOLD, the result SHALL be consumed and start ignored; a new start SHALL be accepted only from IDLE on a later cycle.
REQ-027 in_ready SHALL never be high outside ACCUM, and out_valid SHALL never be high outside HOLD.

Reset
REQ-028 rst=1 SHALL force IDLE and clear acc, out_data, ovf, and remaining on the same edge, regardless of state; it SHALL abort any in-progress job without emitting a result.
REQ-029 After reset, outputs SHALL be: busy=0, in_ready=0, out_valid=0, out_data=0, ovf=0.
REQ-030 rst SHALL take priority over start, in_valid, and out_ready in the same cycle.

Structure
REQ-031 LANES, LANE_W, CNT_W defaults and the FSM state encoding SHALL live in the shared package array_pkg.
REQ-032 Lane-wise addition SHALL be a combinational sub-module array_lane_add (inputs a, b of width W; outputs sum of width W and carry of width LANES), instantiated once.
REQ-033 The controller SHALL hold only the FSM, the remaining counter, and the acc, out_data, and ovf registers.

Verification
REQ-034 count=2; operands 27'o123456701, 27'o123456701 back-to-back -> out_data=27'o246024602, ovf=9'b000111100, out_valid 2 cycles after the 2nd beat.
REQ-035 count=3; operands 27'o111111111 with in_valid gaps of 0, 3, and 1 cycles -> out_data=27'o333333333, ovf=0, and in_ready drops after the 3rd beat.
REQ-036 count=0 -> out_valid 2 cycles after start, out_data=0, ovf=0, with no in_ready pulse.
REQ-037 Result in HOLD with out_ready held low 5 cycles, and start pulsed meanwhile -> out_data stable, no new job; out_ready=1 -> IDLE the next cycle.
REQ-038 count=4, rst asserted after the 2nd beat -> next cycle busy=0, out_data=0, ovf=0; a new job with count=1 and 27'o000000007 -> out_data=27'o000000007.
REQ-039 count=8, all operands 27'o777777777 -> out_data=27'o000000000, ovf=9'h1FF.
